// File: rtl/line_mem_slave.sv
// ---------------------------------------------------------------------------
// line_mem_slave
//
// Wishbone classic single-beat slave that stores whole 64-byte cache lines.
// The backing store is a 128-bit-wide synchronous RAM. Each line is moved as
// four 16-byte beats: beat k covers line bytes [16k+15:16k] and uses RAM
// address {line_index, k}. Every accepted request gets a one-cycle ws_ack.
//
// Handshake: a request is taken only in IDLE when ws_cyc & ws_stb are both
// high. Address, direction, write data and byte mask are captured at that
// point, so the master may drop or change them from the next cycle on. Once
// taken, the transaction always runs to completion, even if ws_cyc/ws_stb
// fall. ws_ack is high for exactly one cycle in the ACK state. Request inputs
// are ignored in ACK, and the next request is sampled in the following IDLE.
//
// Latency, counted from T = the IDLE cycle that sees the request:
//   read  : RAM reads in T+1..T+4, ws_ack and the full ws_dout in T+6
//   write : RAM writes in T+1..T+4, ws_ack in T+5
//
// Optional feature macro: LINE_MEM_ERR_EN
//   When defined, the ws_err port exists. A request whose address bits above
//   the line index are non-zero goes straight to ACK. It then raises ws_err
//   for one cycle in T+1, with no ws_ack and no RAM access.
//   When undefined, the upper address bits are ignored, so addresses alias
//   modulo the capacity.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ws_addr      byte address; line index = ws_addr[ADDR_BITS+5:6]
//   ws_din       512-bit write data, byte i = line offset i
//   ws_dm        64-bit write byte enables
//   ws_we        1 = write line, 0 = read line
//   ws_cyc       bus cycle active
//   ws_stb       request strobe
//   ws_ack       registered one-cycle completion pulse
//   ws_dout      last completed read line
//   ws_err       address error pulse (LINE_MEM_ERR_EN only)
// ---------------------------------------------------------------------------
module line_mem_slave #(
  parameter int ADDR_BITS = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [31:0]    ws_addr,
  input  logic [511:0]   ws_din,
  input  logic [63:0]    ws_dm,
  input  logic           ws_we,
  input  logic           ws_cyc,
  input  logic           ws_stb,
  output logic           ws_ack,
  output logic [511:0]   ws_dout
`ifdef LINE_MEM_ERR_EN
  ,
  output logic           ws_err
`endif
);

  localparam int RAM_AW    = ADDR_BITS + 2;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_LAST = 3'd2,
    ST_WR      = 3'd3,
    ST_ACK     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             beat_q, beat_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [511:0]           din_q, din_d;
  logic [63:0]            dm_q, dm_d;
  logic [511:0]           dout_q, dout_d;
  logic                   ack_q, ack_d;
  // The read capture pipeline follows the RAM's one-cycle read latency.
  // It records which beat the RAM output belongs to in the next cycle.
  logic                   cap_en_q, cap_en_d;
  logic [1:0]             cap_beat_q, cap_beat_d;

  // RAM port
  logic                   ram_we;
  logic                   ram_re;
  logic [RAM_AW-1:0]      ram_addr;
  logic [15:0]            ram_wbe;
  logic [127:0]           ram_wdata;
  logic [127:0]           ram_rdata_q;
  logic [127:0]           mem [RAM_DEPTH];

  logic                   req;

  assign req = ws_cyc & ws_stb;

`ifdef LINE_MEM_ERR_EN
  logic err_q, err_d;
  logic addr_hi_bad;
  logic unused_addr_lo;
  assign addr_hi_bad    = |ws_addr[31:ADDR_BITS+6];
  assign unused_addr_lo = ^ws_addr[5:0];
`else
  // The offset and alias bits carry no meaning in this build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ws_addr[31:ADDR_BITS+6], ws_addr[5:0]};
`endif

  // -------------------------------------------------------------------------
  // Next-state / datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    idx_d      = idx_q;
    din_d      = din_q;
    dm_d       = dm_q;
    dout_d     = dout_q;
    ack_d      = 1'b0;
    cap_en_d   = 1'b0;
    cap_beat_d = beat_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = {idx_q, beat_q};
    ram_wbe    = dm_q[beat_q*16 +: 16];
    ram_wdata  = din_q[beat_q*128 +: 128];
`ifdef LINE_MEM_ERR_EN
    err_d      = 1'b0;
`endif

    // Place the beat that the RAM returned this cycle into the output line.
    if (cap_en_q) begin
      dout_d[cap_beat_q*128 +: 128] = ram_rdata_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d  = ws_addr[ADDR_BITS+5:6];
          din_d  = ws_din;
          dm_d   = ws_dm;
          beat_d = 2'd0;
`ifdef LINE_MEM_ERR_EN
          if (addr_hi_bad) begin
            state_d = ST_ACK;
            err_d   = 1'b1;
          end else
`endif
          begin
            state_d = ws_we ? ST_WR : ST_RD;
          end
        end
      end

      ST_RD: begin
        ram_re     = 1'b1;
        cap_en_d   = 1'b1;
        cap_beat_d = beat_q;
        beat_d     = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = ST_RD_LAST;
        end
      end

      // Beat 3 lands in ws_dout at the end of this cycle, so the ack
      // and the full line become visible together.
      ST_RD_LAST: begin
        state_d = ST_ACK;
        ack_d   = 1'b1;
      end

      ST_WR: begin
        ram_we = 1'b1;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= 2'd0;
      idx_q      <= '0;
      din_q      <= '0;
      dm_q       <= '0;
      dout_q     <= '0;
      ack_q      <= 1'b0;
      cap_en_q   <= 1'b0;
      cap_beat_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      idx_q      <= idx_d;
      din_q      <= din_d;
      dm_q       <= dm_d;
      dout_q     <= dout_d;
      ack_q      <= ack_d;
      cap_en_q   <= cap_en_d;
      cap_beat_q <= cap_beat_d;
    end
  end

`ifdef LINE_MEM_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign ws_err = err_q;
`endif

  // -------------------------------------------------------------------------
  // Line storage: 128-bit words with byte write enables. The RAM is not
  // reset, so its contents survive a reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 16; b++) begin
        if (ram_wbe[b]) begin
          mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
    if (ram_re) begin
      ram_rdata_q <= mem[ram_addr];
    end
  end

  assign ws_ack  = ack_q;
  assign ws_dout = dout_q;

endmodule

// File: tb/tb_line_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_line_mem_slave
//
// Bench for line_mem_slave. It applies a table of single line requests, each
// with a hand-derived expected ack latency and read line. Hand-written
// sequences then cover:
//   - the refill pattern: read, then write, with ws_cyc held high
//   - a reset in the middle of a read
//   - four back-to-back reads with ws_stb held high
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// at that same point.
// ---------------------------------------------------------------------------
module tb_line_mem_slave;

  logic         clk;
  logic         rst_n;
  logic [31:0]  ws_addr;
  logic [511:0] ws_din;
  logic [63:0]  ws_dm;
  logic         ws_we;
  logic         ws_cyc;
  logic         ws_stb;
  logic         ws_ack;
  logic [511:0] ws_dout;
  logic         err_sig;

`ifdef LINE_MEM_ERR_EN
  logic ws_err;
  assign err_sig = ws_err;
`else
  assign err_sig = 1'b0;
`endif

  line_mem_slave #(.ADDR_BITS(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ws_addr (ws_addr),
    .ws_din  (ws_din),
    .ws_dm   (ws_dm),
    .ws_we   (ws_we),
    .ws_cyc  (ws_cyc),
    .ws_stb  (ws_stb),
    .ws_ack  (ws_ack),
    .ws_dout (ws_dout)
`ifdef LINE_MEM_ERR_EN
    ,
    .ws_err  (ws_err)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [511:0] din;
    logic [63:0]  dm;
    logic [511:0] exp_dout;
    bit           exp_err;
  } vec_t;

  vec_t vecs[12];

  // ---------------- checkers ----------------
  task automatic check_int(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [511:0] act,
                            input logic [511:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issue one request in cycle T, then drop ws_cyc/ws_stb and scramble the
  // request inputs. Watch a 12-cycle window and report the cycle offset of
  // the first ack, the number of acks, and the first err cycle.
  task automatic run_req(input logic [31:0] a, input logic we,
                         input logic [511:0] d, input logic [63:0] m,
                         output int lat, output int nack, output int elat);
    @(posedge clk); #1;
    ws_addr = a; ws_we = we; ws_din = d; ws_dm = m;
    ws_cyc  = 1'b1; ws_stb = 1'b1;
    lat = -1; nack = 0; elat = -1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        ws_cyc = 1'b0; ws_stb = 1'b0;
        ws_addr = 32'hFFFF_FFFF; ws_din = '1; ws_dm = '1; ws_we = ~we;
      end
      if (ws_ack) begin
        nack++;
        if (lat < 0) lat = n;
      end
      if (err_sig && elat < 0) elat = n;
    end
  endtask

  function automatic logic [511:0] fill(input logic [7:0] b);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = b;
    return r;
  endfunction

  // ---------------- main ----------------
  logic [511:0] ramp, l3, l11, xf0, last_rd;
  int lat, nack, elat;
  int ack_at[$];

  initial begin
    for (int i = 0; i < 64; i++) begin
      ramp[8*i +: 8] = 8'(i);
      xf0[8*i +: 8]  = 8'hF0 ^ 8'(i);
    end
    l3 = ramp;
    for (int i = 8; i < 16; i++) l3[8*i +: 8] = 8'hAA;
    l11 = l3;
    l11[511:504] = 8'h77;

    vecs[0]  = '{32'h0000_0480, 1'b1, ramp,        '1,                         '0,          1'b0};
    vecs[1]  = '{32'h0000_0480, 1'b0, '0,          '0,                         ramp,        1'b0};
    vecs[2]  = '{32'h0000_0480, 1'b1, fill(8'hAA), 64'h0000_0000_0000_FF00,    '0,          1'b0};
    vecs[3]  = '{32'h0000_0480, 1'b0, '0,          '0,                         l3,          1'b0};
    vecs[4]  = '{32'h0000_8000, 1'b1, fill(8'h5C), '1,                         '0,          1'b0};
    vecs[5]  = '{32'h0000_8000, 1'b1, fill(8'h11), 64'h0,                      '0,          1'b0};
    vecs[6]  = '{32'h0000_8000, 1'b0, '0,          '0,                         fill(8'h5C), 1'b0};
    vecs[7]  = '{32'h0000_0000, 1'b1, xf0,         '1,                         '0,          1'b0};
`ifdef LINE_MEM_ERR_EN
    vecs[8]  = '{32'h0001_0000, 1'b0, '0,          '0,                         '0,          1'b1};
`else
    vecs[8]  = '{32'h0001_0000, 1'b0, '0,          '0,                         xf0,         1'b0};
`endif
    vecs[9]  = '{32'h0000_FFC0, 1'b1, fill(8'h3C), '1,                         '0,          1'b0};
    vecs[10] = '{32'h0000_0480, 1'b1, fill(8'h77), 64'h8000_0000_0000_0000,    '0,          1'b0};
    vecs[11] = '{32'h0000_048F, 1'b0, '0,          '0,                         l11,         1'b0};

    rst_n = 1'b0; ws_addr = '0; ws_din = '0; ws_dm = '0;
    ws_we = 1'b0; ws_cyc = 1'b0; ws_stb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_ack", int'(ws_ack), 0);
    check_line("reset_dout", ws_dout, '0);
    rst_n = 1'b1;
    last_rd = '0;

    // ---- table-driven single requests ----
    for (int v = 0; v < 12; v++) begin
      run_req(vecs[v].addr, vecs[v].we, vecs[v].din, vecs[v].dm, lat, nack, elat);
      if (vecs[v].exp_err) begin
        check_int($sformatf("v%0d_err_cycle", v), elat, 1);
        check_int($sformatf("v%0d_no_ack", v), nack, 0);
        check_line($sformatf("v%0d_dout_kept", v), ws_dout, last_rd);
      end else begin
        check_int($sformatf("v%0d_ack_cycle", v), lat, vecs[v].we ? 5 : 6);
        check_int($sformatf("v%0d_ack_count", v), nack, 1);
        if (vecs[v].we) begin
          check_line($sformatf("v%0d_dout_kept", v), ws_dout, last_rd);
        end else begin
          check_line($sformatf("v%0d_dout", v), ws_dout, vecs[v].exp_dout);
          last_rd = vecs[v].exp_dout;
        end
      end
    end

    // ---- refill: read line 0x3FF, then write line 0x005 under one ws_cyc ----
    ack_at.delete();
    @(posedge clk); #1;
    ws_addr = 32'h0000_FFC0; ws_we = 1'b0; ws_cyc = 1'b1; ws_stb = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) ws_stb = 1'b0;
      if (ws_ack) ack_at.push_back(n);
      if (n == 6) check_line("refill_rd_dout", ws_dout, fill(8'h3C));
      if (n == 7) begin
        ws_addr = 32'h0000_0140; ws_we = 1'b1; ws_din = ramp; ws_dm = '1;
        ws_stb = 1'b1;
      end
      if (n == 8) ws_stb = 1'b0;
    end
    ws_cyc = 1'b0;
    check_int("refill_ack_count", ack_at.size(), 2);
    check_int("refill_rd_ack", (ack_at.size() > 0) ? ack_at[0] : -1, 6);
    check_int("refill_wr_ack", (ack_at.size() > 1) ? ack_at[1] : -1, 12);
    run_req(32'h0000_0140, 1'b0, '0, '0, lat, nack, elat);
    check_line("refill_wr_readback", ws_dout, ramp);

    // ---- reset at T+3 of a read ----
    ack_at.delete();
    @(posedge clk); #1;
    ws_addr = 32'h0000_0480; ws_we = 1'b0; ws_cyc = 1'b1; ws_stb = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin ws_cyc = 1'b0; ws_stb = 1'b0; end
      if (n == 3) rst_n = 1'b0;
      if (n == 5) rst_n = 1'b1;
      if (ws_ack) ack_at.push_back(n);
    end
    check_int("rst_mid_no_ack", ack_at.size(), 0);
    check_line("rst_mid_dout", ws_dout, '0);
    run_req(32'h0000_0480, 1'b0, '0, '0, lat, nack, elat);
    check_int("post_rst_ack_cycle", lat, 6);
    check_line("post_rst_dout", ws_dout, l11);

    // ---- four reads with ws_stb held high ----
    ack_at.delete();
    @(posedge clk); #1;
    ws_addr = 32'h0000_8000; ws_we = 1'b0; ws_cyc = 1'b1; ws_stb = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk); #1;
      if (ws_ack) ack_at.push_back(n);
      if (n == 27) begin ws_stb = 1'b0; ws_cyc = 1'b0; end
    end
    check_int("stream_ack_count", ack_at.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check_int($sformatf("stream_ack%0d", k),
                (ack_at.size() > k) ? ack_at[k] : -1, 6 + 7*k);
    end
    check_line("stream_dout", ws_dout, fill(8'h5C));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog on the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
